// File: rtl/lbist_pkg.sv
// Shared LBIST types: sequencer states and counter-width helper.
// Also imported by the MISR/TAP wrapper.
package lbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } lbist_state_e;

  // Width needed to hold values 0..n-1, never less than 1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lbist_down_cnt.sv
// Loadable down counter with zero flag.
// Used to time shift and unload windows.
module lbist_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: LFSR, scan shift/capture, MISR, signature.
// Define LBIST_GOLDEN_CMP_EN to enable the golden-signature comparator.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int               SCAN_LEN   = 64,
  parameter int               N_PATTERNS = 1024,
  parameter int               MISR_W     = 32,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [MISR_W-1:0]                 misr_sig_i,
  output logic                              lfsr_init_o,
  output logic                              lfsr_en_o,
  output logic                              scan_en_o,
  output logic                              capture_o,
  output logic                              misr_clr_o,
  output logic                              misr_en_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic [MISR_W-1:0]                 sig_o,
  output logic [cnt_w(N_PATTERNS+1)-1:0]    pat_cnt_o
);

  localparam int PW = cnt_w(N_PATTERNS + 1);
  localparam int SW = cnt_w(SCAN_LEN);

  lbist_state_e state, nxt;

  logic          sh_zero;
  logic          sh_load;
  logic          sh_dec;
  logic [PW-1:0] pat_inc;
  logic [PW-1:0] pat_d;
  logic          sig_ld;
  logic          lfsr_init_d;
  logic          lfsr_en_d;
  logic          scan_en_d;
  logic          capture_d;
  logic          misr_clr_d;
  logic          misr_en_d;
  logic          busy_d;
  logic          done_d;
  logic          pass_d;

  assign pat_inc = pat_cnt_o + 1'b1;

  // Reloaded on entry to every shift/unload window.
  assign sh_load = (state == ST_INIT) || (state == ST_CAPTURE);
  assign sh_dec  = (state == ST_SHIFT) || (state == ST_UNLOAD);

  lbist_down_cnt #(
    .W (SW)
  ) u_shift_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .load_val (SW'(SCAN_LEN - 1)),
    .dec      (sh_dec),
    .zero_o   (sh_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:    if (start_i) nxt = ST_INIT;
      ST_INIT:    nxt = ST_SHIFT;
      ST_SHIFT:   if (sh_zero) nxt = ST_CAPTURE;
      ST_CAPTURE: nxt = (pat_inc == PW'(N_PATTERNS)) ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:  if (sh_zero) nxt = ST_DONE;
      ST_DONE:    if (start_i) nxt = ST_INIT;
      default:    nxt = ST_IDLE;
    endcase
    if (abort_i) nxt = ST_IDLE;
  end

  always_comb begin
    pat_d = pat_cnt_o;
    if ((nxt == ST_IDLE) || (nxt == ST_INIT)) begin
      pat_d = '0;
    end else if (state == ST_CAPTURE) begin
      pat_d = pat_inc;
    end
  end

  assign sig_ld = (state == ST_UNLOAD) && (nxt == ST_DONE);

  // Outputs are decoded from the next state so they are registered.
  // The first load is not compacted: the chains hold junk until then.
  always_comb begin
    lfsr_init_d = (nxt == ST_INIT);
    misr_clr_d  = (nxt == ST_INIT);
    lfsr_en_d   = (nxt == ST_SHIFT);
    scan_en_d   = (nxt == ST_SHIFT) || (nxt == ST_UNLOAD);
    capture_d   = (nxt == ST_CAPTURE);
    misr_en_d   = ((nxt == ST_SHIFT) && (pat_d != '0))
                || (nxt == ST_UNLOAD);
    busy_d      = (nxt == ST_INIT) || (nxt == ST_SHIFT)
                || (nxt == ST_CAPTURE) || (nxt == ST_UNLOAD);
    done_d      = (nxt == ST_DONE);
  end

`ifdef LBIST_GOLDEN_CMP_EN
  always_comb begin
    pass_d = 1'b0;
    if (sig_ld) begin
      pass_d = (misr_sig_i == GOLDEN_SIG);
    end else if (nxt == ST_DONE) begin
      pass_d = pass_o;
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN_SIG;
  assign pass_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_init_o <= 1'b0;
      lfsr_en_o   <= 1'b0;
      scan_en_o   <= 1'b0;
      capture_o   <= 1'b0;
      misr_clr_o  <= 1'b0;
      misr_en_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      pat_cnt_o   <= '0;
    end else begin
      lfsr_init_o <= lfsr_init_d;
      lfsr_en_o   <= lfsr_en_d;
      scan_en_o   <= scan_en_d;
      capture_o   <= capture_d;
      misr_clr_o  <= misr_clr_d;
      misr_en_o   <= misr_en_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      pass_o      <= pass_d;
      pat_cnt_o   <= pat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_o <= '0;
    end else if (sig_ld) begin
      sig_o <= misr_sig_i;
    end
  end

endmodule
